// File: rtl/hiscore_uploader.sv
// hiscore_uploader: streams the hiscore region of game work RAM back to the
// HPS over the ioctl upload channel. The CPU is paused and given time to settle
// before any RAM read, so reads never collide with the running game. A rising
// edge on save_trigger while idle raises ioctl_upload_req to ask the HPS for
// an autosave upload.
module hiscore_uploader #(
  parameter int          RAM_AW       = 11,
  parameter int          LENGTH       = 2048,
  parameter logic [7:0]  UPLOAD_INDEX = 8'd4,
  parameter int          SETTLE       = 4
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic              ioctl_upload_req,
  input  logic              save_trigger,
  output logic              pause_req,
  input  logic              paused,
  output logic [RAM_AW-1:0] ram_addr,
  input  logic [7:0]        ram_data,
  output logic              busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PAUSE,
    ST_SETTLE,
    ST_READY,
    ST_FETCH,
    ST_CAPTURE
  } state_t;

  // Full-width length so out-of-range addresses never alias into the RAM.
  localparam logic [24:0] LENGTH_A    = 25'(LENGTH);
  localparam logic [3:0]  SETTLE_LOAD = 4'(SETTLE - 1);

  state_t            state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic              save_reg;
  logic [7:0]        din_reg, din_next;
  logic              wait_reg, wait_next;
  logic              req_reg, req_next;
  logic              pause_reg, pause_next;
  logic [RAM_AW-1:0] ram_addr_reg, ram_addr_next;
  logic              busy_reg, busy_next;

  logic sess;
  logic save_rise;
  logic addr_in_range;

  assign sess          = ioctl_upload && (ioctl_index == UPLOAD_INDEX);
  assign save_rise     = save_trigger && !save_reg;
  assign addr_in_range = (ioctl_addr < LENGTH_A);

  assign ioctl_din        = din_reg;
  assign ioctl_wait       = wait_reg;
  assign ioctl_upload_req = req_reg;
  assign pause_req        = pause_reg;
  assign ram_addr         = ram_addr_reg;
  assign busy             = busy_reg;

  // State and output registers; everything clears on reset.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      save_reg     <= 1'b0;
      din_reg      <= '0;
      wait_reg     <= 1'b0;
      req_reg      <= 1'b0;
      pause_reg    <= 1'b0;
      ram_addr_reg <= '0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      save_reg     <= save_trigger;
      din_reg      <= din_next;
      wait_reg     <= wait_next;
      req_reg      <= req_next;
      pause_reg    <= pause_next;
      ram_addr_reg <= ram_addr_next;
      busy_reg     <= busy_next;
    end
  end

  // Next-state and next-output logic. Losing the session beats everything,
  // then losing the pause; only then are HPS reads serviced.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    din_next      = din_reg;
    wait_next     = wait_reg;
    req_next      = req_reg;
    pause_next    = pause_reg;
    ram_addr_next = ram_addr_reg;

    // A session starting satisfies any outstanding autosave request.
    if (sess) req_next = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (sess) begin
          state_next = ST_PAUSE;
          pause_next = 1'b1;
          wait_next  = 1'b1;
        end else if (save_rise) begin
          req_next = 1'b1;
        end
      end
      default: begin
        if (!sess) begin
          // Session gone: release the CPU and the HPS, keep data registers.
          state_next = ST_IDLE;
          pause_next = 1'b0;
          wait_next  = 1'b0;
        end else begin
          case (state_reg)
            ST_PAUSE: begin
              pause_next = 1'b1;
              wait_next  = 1'b1;
              if (paused) begin
                cnt_next   = SETTLE_LOAD;
                state_next = ST_SETTLE;
              end
            end
            ST_SETTLE: begin
              if (cnt_reg == 4'd0) begin
                state_next = ST_READY;
                wait_next  = 1'b0;
              end else begin
                cnt_next = cnt_reg - 4'd1;
              end
            end
            ST_READY: begin
              if (!paused) begin
                state_next = ST_PAUSE;
                wait_next  = 1'b1;
              end else if (ioctl_rd) begin
                if (addr_in_range) begin
                  ram_addr_next = ioctl_addr[RAM_AW-1:0];
                  wait_next     = 1'b1;
                  state_next    = ST_FETCH;
                end else begin
                  din_next = 8'hFF;
                end
              end
            end
            ST_FETCH: begin
              if (!paused) begin
                state_next = ST_PAUSE;
                wait_next  = 1'b1;
              end else begin
                state_next = ST_CAPTURE;
              end
            end
            ST_CAPTURE: begin
              if (!paused) begin
                // Abort: the fetched byte is discarded.
                state_next = ST_PAUSE;
                wait_next  = 1'b1;
              end else begin
                din_next   = ram_data;
                wait_next  = 1'b0;
                state_next = ST_READY;
              end
            end
            default: begin
              state_next = ST_IDLE;
            end
          endcase
        end
      end
    endcase

    busy_next = (state_next != ST_IDLE);
  end

endmodule

// File: tb/tb_hiscore_uploader.sv
// Testbench for hiscore_uploader: drives the ioctl upload protocol against a
// behavioural RAM, with expectations derived from address/length rules and
// fixed protocol latencies.
module tb_hiscore_uploader;

  localparam int SETTLE = 4;
  localparam int LENGTH = 2048;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_upload = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_rd = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic        ioctl_upload_req;
  logic        save_trigger = 1'b0;
  logic        pause_req;
  logic        paused = 1'b0;
  logic [10:0] ram_addr;
  logic [7:0]  ram_data = 8'd0;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [0:LENGTH-1];

  hiscore_uploader #(
    .RAM_AW(11), .LENGTH(LENGTH), .UPLOAD_INDEX(8'd4), .SETTLE(SETTLE)
  ) dut (
    .clk_sys(clk_sys), .reset(reset),
    .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
    .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
    .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
    .ioctl_upload_req(ioctl_upload_req), .save_trigger(save_trigger),
    .pause_req(pause_req), .paused(paused),
    .ram_addr(ram_addr), .ram_data(ram_data), .busy(busy)
  );

  always #5 clk_sys = ~clk_sys;

  // Synchronous RAM: data valid one cycle after the address.
  always @(posedge clk_sys) ram_data <= mem[ram_addr];

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    total++;
    if ({ioctl_din, ioctl_wait, ioctl_upload_req, pause_req, ram_addr, busy} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got din=%h wait=%b req=%b pause=%b ra=%h busy=%b, want all 0",
               ioctl_din, ioctl_wait, ioctl_upload_req, pause_req, ram_addr, busy);
    end
    reset = 1'b0;
    tick();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_wrong_index();
    for (int i = 0; i < 8; i++) begin
      logic [7:0] idx;
      idx = (i == 0) ? 8'd0 : 8'($urandom);
      if (idx == 8'd4) idx = 8'd5;
      ioctl_index  = idx;
      ioctl_upload = 1'b1;
      repeat (2) tick();
      total++;
      if ({pause_req, busy, ioctl_wait} !== 3'b000) begin
        bad++;
        $display("FAIL wrong_index: idx=%0d got pause=%b busy=%b wait=%b want 000",
                 idx, pause_req, busy, ioctl_wait);
      end
    end
    ioctl_upload = 1'b0;
    ioctl_index  = 8'd0;
    tick();
  endtask

  task automatic open_session();
    ioctl_upload = 1'b1;
    ioctl_index  = 8'd4;
    tick();
    total++;
    if ({pause_req, ioctl_wait, busy} !== 3'b111) begin
      bad++;
      $display("FAIL open_session: got pause=%b wait=%b busy=%b want 111", pause_req, ioctl_wait, busy);
    end
  endtask

  task automatic close_session();
    ioctl_upload = 1'b0;
    tick();
  endtask

  // Raise paused right after an edge; wait must drop SETTLE+1 edges later.
  task automatic settle_and_check(input string tag);
    paused = 1'b1;
    for (int k = 1; k <= SETTLE + 1; k++) begin
      logic exp_wait;
      tick();
      exp_wait = (k <= SETTLE);
      total++;
      if (ioctl_wait !== exp_wait || pause_req !== 1'b1) begin
        bad++;
        $display("FAIL %s_settle k=%0d: got wait=%b pause=%b want wait=%b pause=1",
                 tag, k, ioctl_wait, pause_req, exp_wait);
      end
    end
  endtask

  task automatic do_read(input logic [24:0] a, input bit poke);
    logic [7:0]  exp;
    logic [10:0] prev_ra;
    prev_ra = ram_addr;
    exp = (a < 25'(LENGTH)) ? mem[a[10:0]] : 8'hFF;
    ioctl_addr = a;
    ioctl_rd   = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    if (a < 25'(LENGTH)) begin
      total++;
      if (ram_addr !== a[10:0] || ioctl_wait !== 1'b1) begin
        bad++;
        $display("FAIL read_issue a=%h: got ra=%h wait=%b want ra=%h wait=1", a, ram_addr, ioctl_wait, a[10:0]);
      end
      if (poke) begin
        ioctl_rd   = 1'b1;
        ioctl_addr = 25'($urandom_range(0, LENGTH - 1));
      end
      tick();
      ioctl_rd = 1'b0;
      total++;
      if (ram_addr !== a[10:0] || ioctl_wait !== 1'b1) begin
        bad++;
        $display("FAIL read_hold a=%h: got ra=%h wait=%b want ra=%h wait=1", a, ram_addr, ioctl_wait, a[10:0]);
      end
      tick();
      total++;
      if (ioctl_din !== exp || ioctl_wait !== 1'b0) begin
        bad++;
        $display("FAIL read_data a=%h: got din=%h wait=%b want din=%h wait=0", a, ioctl_din, ioctl_wait, exp);
      end
    end else begin
      total++;
      if (ioctl_din !== 8'hFF || ioctl_wait !== 1'b0 || ram_addr !== prev_ra) begin
        bad++;
        $display("FAIL read_oob a=%h: got din=%h wait=%b ra=%h want din=ff wait=0 ra=%h",
                 a, ioctl_din, ioctl_wait, ram_addr, prev_ra);
      end
    end
    $display("read addr=%h poke=%0d din=%h expected=%h", a, poke, ioctl_din, exp);
  endtask

  task automatic test_settle();
    open_session();
    repeat (3) begin
      tick();
      total++;
      if (ioctl_wait !== 1'b1 || pause_req !== 1'b1) begin
        bad++;
        $display("FAIL pause_hold: got wait=%b pause=%b want 1 1", ioctl_wait, pause_req);
      end
    end
    settle_and_check("first");
  endtask

  task automatic test_read();
    mem[11'h012] = 8'hA5;
    do_read(25'h012, 1'b0);
    do_read(25'h800, 1'b0);
    do_read(25'h1000800, 1'b0);
    do_read(25'h7FF, 1'b1);
    for (int i = 0; i < 24; i++) begin
      logic [24:0] a;
      if ($urandom_range(0, 2) == 0) a = 25'($urandom_range(LENGTH, 33554431));
      else                           a = 25'($urandom_range(0, LENGTH - 1));
      do_read(a, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_pause_drop();
    logic [7:0]  din_before;
    logic [24:0] a;
    a = 25'h123;
    din_before = ioctl_din;
    mem[a[10:0]] = ~din_before;
    ioctl_addr = a;
    ioctl_rd   = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    paused   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      total++;
      if (ioctl_wait !== 1'b1 || pause_req !== 1'b1 || busy !== 1'b1 || ioctl_din !== din_before) begin
        bad++;
        $display("FAIL pause_drop k=%0d: got wait=%b pause=%b busy=%b din=%h want 1 1 1 din=%h",
                 k, ioctl_wait, pause_req, busy, ioctl_din, din_before);
      end
    end
    settle_and_check("resume");
    do_read(a, 1'b0);
  endtask

  task automatic test_session_end();
    logic [7:0]  din_snap;
    logic [10:0] ra_snap;
    din_snap = ioctl_din;
    ra_snap  = ram_addr;
    ioctl_upload = 1'b0;
    tick();
    total++;
    if ({busy, pause_req, ioctl_wait} !== 3'b000 || ioctl_din !== din_snap || ram_addr !== ra_snap) begin
      bad++;
      $display("FAIL session_end: got busy=%b pause=%b wait=%b din=%h ra=%h want 000 din=%h ra=%h",
               busy, pause_req, ioctl_wait, ioctl_din, ram_addr, din_snap, ra_snap);
    end
    paused = 1'b0;
    tick();
  endtask

  task automatic test_autosave();
    save_trigger = 1'b1;
    tick();
    total++;
    if (ioctl_upload_req !== 1'b1) begin bad++; $display("FAIL autosave_set: got %b want 1", ioctl_upload_req); end
    repeat (2) tick();
    save_trigger = 1'b0;
    repeat (2) tick();
    total++;
    if (ioctl_upload_req !== 1'b1) begin bad++; $display("FAIL autosave_hold: got %b want 1", ioctl_upload_req); end
    open_session();
    total++;
    if (ioctl_upload_req !== 1'b0) begin bad++; $display("FAIL autosave_clear: got %b want 0", ioctl_upload_req); end
    save_trigger = 1'b1;
    tick();
    save_trigger = 1'b0;
    tick();
    close_session();
    repeat (2) tick();
    total++;
    if (ioctl_upload_req !== 1'b0) begin bad++; $display("FAIL autosave_busy_drop: got %b want 0", ioctl_upload_req); end
  endtask

  task automatic test_simultaneous();
    save_trigger = 1'b1;
    ioctl_upload = 1'b1;
    ioctl_index  = 8'd4;
    tick();
    total++;
    if (ioctl_upload_req !== 1'b0 || pause_req !== 1'b1) begin
      bad++;
      $display("FAIL simultaneous: got req=%b pause=%b want req=0 pause=1", ioctl_upload_req, pause_req);
    end
    tick();
    close_session();
    total++;
    if (ioctl_upload_req !== 1'b0) begin bad++; $display("FAIL simultaneous_after: got %b want 0", ioctl_upload_req); end
    save_trigger = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_fetch();
    open_session();
    settle_and_check("rst");
    ioctl_addr = 25'h055;
    ioctl_rd   = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    total++;
    if (ioctl_wait !== 1'b1 || pause_req !== 1'b1) begin
      bad++;
      $display("FAIL rst_pre_fetch: got wait=%b pause=%b want 1 1", ioctl_wait, pause_req);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({ioctl_din, ioctl_wait, ioctl_upload_req, pause_req, ram_addr, busy} !== '0) begin
      bad++;
      $display("FAIL rst_async: got din=%h wait=%b req=%b pause=%b ra=%h busy=%b want all 0",
               ioctl_din, ioctl_wait, ioctl_upload_req, pause_req, ram_addr, busy);
    end
    ioctl_upload = 1'b0;
    paused       = 1'b0;
    tick();
    reset = 1'b0;
    repeat (3) tick();
    total++;
    if (busy !== 1'b0 || pause_req !== 1'b0) begin
      bad++;
      $display("FAIL rst_release_idle: got busy=%b pause=%b want 0 0", busy, pause_req);
    end
  endtask

  initial begin
    for (int i = 0; i < LENGTH; i++) mem[i] = 8'($urandom);
    test_reset();
    test_wrong_index();
    test_autosave();
    test_simultaneous();
    test_settle();
    test_read();
    test_pause_drop();
    test_session_end();
    test_reset_mid_fetch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
